scc68070_timer_unit: RTL and testbench

// Parametrised SCC68070 on-chip timer block: prescaler, T0 auto-reload timer,
// and two channels T1/T2 with match, capture and event-count modes driven by external pins.

---
 rtl/scc68070_timer_if.sv | 13 +
 rtl/scc68070_timer_unit.sv | 204 ++++++++++++++++++++
 tb/tb_scc68070_timer_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/scc68070_timer_if.sv
// Register-window bus between the SCC68070 peripheral decoder and the timer block.
interface scc68070_timer_if;
    logic        cs;
    logic [2:0]  addr;
    logic        we;
    logic        uds;
    logic        lds;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (output cs, addr, we, uds, lds, wdata, input rdata);
    modport slave  (input cs, addr, we, uds, lds, wdata, output rdata);
endinterface

// File: rtl/scc68070_timer_unit.sv
// SCC68070 timer block: prescaler, auto-reload T0, and two match/capture/event-count
// channels fed from asynchronous pins. TIMER_W is expected to be at least 16.
module scc68070_timer_unit #(
    parameter int PRESCALE_DIV = 96,
    parameter int TIMER_W      = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    scc68070_timer_if.slave  bus,
    input  logic             t1_in,
    input  logic             t2_in,
    output logic             irq
);
    localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [TIMER_W-1:0] ONES = '1;

    logic [PW-1:0]      presc_reg, presc_next;
    logic               tick;
    logic [TIMER_W-1:0] t0_reg, t0_next, t0_inc;
    logic [TIMER_W-1:0] reload_reg, reload_next;
    logic [7:0]         cr_reg, cr_next;
    logic               t0_ov_reg, t0_ov_next;

    logic               wr_en, sr_wr, cr_wr, reload_wr, t0_wr;
    logic [TIMER_W-1:0] lane_mask, lane_data;

    logic [1:0]                  pins;
    logic [1:0][TIMER_W-1:0]     ch_val;
    logic [1:0]                  ma_flag, cap_flag, ov_flag;
    logic [7:0]                  sr;

    function automatic logic [TIMER_W-1:0] lane_merge(
        input logic [TIMER_W-1:0] cur,
        input logic [TIMER_W-1:0] mask,
        input logic [TIMER_W-1:0] data
    );
        return (cur & ~mask) | (data & mask);
    endfunction

    assign wr_en     = bus.cs && bus.we;
    assign sr_wr     = wr_en && (bus.addr == 3'd0) && bus.uds;
    assign cr_wr     = wr_en && (bus.addr == 3'd0) && bus.lds;
    assign reload_wr = wr_en && (bus.addr == 3'd1);
    assign t0_wr     = wr_en && (bus.addr == 3'd2);

    // Byte-lane enables expanded to timer width; bits above the bus are never written.
    for (genvar gi = 0; gi < TIMER_W; gi++) begin : g_lane
        if (gi < 8) begin : g_lo
            assign lane_mask[gi] = bus.lds;
            assign lane_data[gi] = bus.wdata[gi];
        end else if (gi < 16) begin : g_hi
            assign lane_mask[gi] = bus.uds;
            assign lane_data[gi] = bus.wdata[gi];
        end else begin : g_ext
            assign lane_mask[gi] = 1'b0;
            assign lane_data[gi] = 1'b0;
        end
    end

    assign tick   = (presc_reg == PW'(PRESCALE_DIV - 1));
    assign t0_inc = (t0_reg == ONES) ? reload_reg : t0_reg + 1'b1;

    always_comb begin
        presc_next  = tick ? '0 : presc_reg + 1'b1;
        t0_next     = t0_reg;
        reload_next = reload_reg;
        cr_next     = cr_reg;
        if (tick) begin
            t0_next = t0_inc;
        end
        if (t0_wr) begin
            t0_next = lane_merge(t0_next, lane_mask, lane_data);
        end
        if (reload_wr) begin
            reload_next = lane_merge(reload_reg, lane_mask, lane_data);
        end
        if (cr_wr) begin
            cr_next = bus.wdata[7:0];
        end
        // Set beats a same-cycle write-1-to-clear.
        t0_ov_next = (tick && (t0_reg == ONES)) ||
                     (t0_ov_reg && !(sr_wr && bus.wdata[15]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg  <= '0;
            t0_reg     <= '0;
            reload_reg <= '0;
            cr_reg     <= '0;
            t0_ov_reg  <= 1'b0;
        end else begin
            presc_reg  <= presc_next;
            t0_reg     <= t0_next;
            reload_reg <= reload_next;
            cr_reg     <= cr_next;
            t0_ov_reg  <= t0_ov_next;
        end
    end

    assign pins = {t2_in, t1_in};

    // Channel 0 is T1 (CR[7:4], SR[14:12]); channel 1 is T2 (CR[3:0], SR[11:9]).
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        localparam logic [2:0] CH_ADDR = 3'(3 + gi);
        localparam int CR_EV = 7 - 4 * gi;
        localparam int CR_MD = 5 - 4 * gi;
        localparam int SR_MA = 14 - 3 * gi;

        logic [SYNC_STAGES-1:0] sync_reg;
        logic                   prev_reg;
        logic [TIMER_W-1:0]     cnt_reg, cnt_next;
        logic                   ma_reg, cap_reg, ov_reg;
        logic                   ma_next, cap_next, ov_next;
        logic                   ma_set, cap_set, ov_set;
        logic [1:0]             ev, md;
        logic                   pin_s, edge_hit;

        assign ev       = cr_reg[CR_EV -: 2];
        assign md       = cr_reg[CR_MD -: 2];
        assign pin_s    = sync_reg[SYNC_STAGES-1];
        assign edge_hit = (ev[0] && pin_s && !prev_reg) || (ev[1] && !pin_s && prev_reg);

        always_comb begin
            cnt_next = cnt_reg;
            ma_set   = 1'b0;
            cap_set  = 1'b0;
            ov_set   = 1'b0;
            case (md)
                2'b01: begin
                    // Match against the value T0 is about to take, so the flag lands with it.
                    if (tick && (t0_inc == cnt_reg)) begin
                        ma_set = 1'b1;
                    end
                end
                2'b10: begin
                    if (edge_hit) begin
                        cnt_next = t0_reg;
                        cap_set  = 1'b1;
                    end
                end
                2'b11: begin
                    if (edge_hit) begin
                        if (cnt_reg == ONES) begin
                            cnt_next = '0;
                            ov_set   = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (wr_en && (bus.addr == CH_ADDR)) begin
                cnt_next = lane_merge(cnt_next, lane_mask, lane_data);
            end
            ma_next  = ma_set  || (ma_reg  && !(sr_wr && bus.wdata[SR_MA]));
            cap_next = cap_set || (cap_reg && !(sr_wr && bus.wdata[SR_MA-1]));
            ov_next  = ov_set  || (ov_reg  && !(sr_wr && bus.wdata[SR_MA-2]));
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_reg <= '0;
                prev_reg <= 1'b0;
                cnt_reg  <= '0;
                ma_reg   <= 1'b0;
                cap_reg  <= 1'b0;
                ov_reg   <= 1'b0;
            end else begin
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], pins[gi]};
                prev_reg <= pin_s;
                cnt_reg  <= cnt_next;
                ma_reg   <= ma_next;
                cap_reg  <= cap_next;
                ov_reg   <= ov_next;
            end
        end

        assign ch_val[gi]   = cnt_reg;
        assign ma_flag[gi]  = ma_reg;
        assign cap_flag[gi] = cap_reg;
        assign ov_flag[gi]  = ov_reg;
    end

    assign sr  = {t0_ov_reg, ma_flag[0], cap_flag[0], ov_flag[0],
                  ma_flag[1], cap_flag[1], ov_flag[1], 1'b0};
    assign irq = |sr[7:1];

    always_comb begin
        bus.rdata = 16'h0000;
        if (bus.cs) begin
            case (bus.addr)
                3'd0:    bus.rdata = {sr, cr_reg};
                3'd1:    bus.rdata = reload_reg[15:0];
                3'd2:    bus.rdata = t0_reg[15:0];
                3'd3:    bus.rdata = ch_val[0][15:0];
                3'd4:    bus.rdata = ch_val[1][15:0];
                default: bus.rdata = 16'h0000;
            endcase
        end
    end
endmodule

// File: tb/tb_scc68070_timer_unit.sv
// Directed bench for the SCC68070 timer block with a 4-cycle prescaler.
module tb_scc68070_timer_unit;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic t1_in = 1'b0;
    logic t2_in = 1'b0;
    logic irq;
    int   tests = 0;
    int   fails = 0;

    scc68070_timer_if bus_if();

    scc68070_timer_unit #(
        .PRESCALE_DIV(4),
        .TIMER_W(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if),
        .t1_in(t1_in),
        .t2_in(t2_in),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic u, input logic l);
        @(negedge clk);
        bus_if.cs    = 1'b1;
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.uds   = u;
        bus_if.lds   = l;
        @(negedge clk);
        bus_if.cs  = 1'b0;
        bus_if.we  = 1'b0;
        bus_if.uds = 1'b0;
        bus_if.lds = 1'b0;
        $display("[TB] wr addr=%0d data=%04h uds=%0d lds=%0d", a, d, u, l);
    endtask

    // Combinational read taken within the current low clock phase.
    task automatic peek(input logic [2:0] a, output logic [15:0] d);
        bus_if.cs   = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = a;
        #1;
        d = bus_if.rdata;
        bus_if.cs = 1'b0;
    endtask

    logic [15:0] d, d2, tgt;
    logic        found;

    initial begin
        bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.addr = 3'd0;
        bus_if.uds = 1'b0; bus_if.lds = 1'b0; bus_if.wdata = 16'h0000;
        step(3);
        reset = 1'b0;
        for (int a = 0; a < 5; a++) begin
            peek(3'(a), d);
            chk($sformatf("reset_word%0d", a), d, 16'h0000);
        end
        chk("reset_irq", 16'(irq), 16'h0000);

        // T0 auto-reload overflow and W1C of t0_ov
        wr(3'd1, 16'hFFFE, 1'b1, 1'b1);
        wr(3'd2, 16'hFFFD, 1'b1, 1'b1);
        wr(3'd0, 16'hFE00, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            peek(3'd0, d);
            found = d[15];
        end
        chk("t0_ov_seen", 16'(found), 16'h0001);
        peek(3'd2, d);
        chk("t0_after_reload", d, 16'hFFFE);
        chk("irq_on_ov", 16'(irq), 16'h0001);
        wr(3'd0, 16'h8000, 1'b1, 1'b0);
        peek(3'd0, d);
        chk("sr_after_w1c", {8'h00, d[15:8]}, 16'h0000);
        chk("irq_after_w1c", 16'(irq), 16'h0000);

        // Channel 1 event count on rising edges
        wr(3'd0, 16'h0070, 1'b0, 1'b1);
        wr(3'd3, 16'h0000, 1'b1, 1'b1);
        repeat (5) begin
            @(negedge clk); t1_in = 1'b1;
            step(3);        t1_in = 1'b0;
            step(3);
        end
        step(4);
        peek(3'd3, d);
        chk("t1_count5", d, 16'h0005);
        peek(3'd0, d);
        chk("t1_ov_idle", 16'(d[12]), 16'h0000);
        wr(3'd3, 16'hFFFF, 1'b1, 1'b1);
        t1_in = 1'b1;
        step(3);
        t1_in = 1'b0;
        step(4);
        peek(3'd3, d);
        chk("t1_wrap", d, 16'h0000);
        peek(3'd0, d);
        chk("t1_ov_set", 16'(d[12]), 16'h0001);

        // Channel 2 capture on both edges, checking pin-to-flag latency
        wr(3'd0, 16'h007E, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tgt = (k == 0) ? 16'h1234 : 16'h5678;
            wr(3'd0, 16'h0400, 1'b1, 1'b0);
            wr(3'd2, tgt - 16'd1, 1'b1, 1'b1);
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                peek(3'd2, d);
                found = (d == tgt);
            end
            chk("cap_align", 16'(found), 16'h0001);
            t2_in = ~t2_in;
            @(negedge clk); peek(3'd0, d);
            chk("cap_lat1", 16'(d[10]), 16'h0000);
            @(negedge clk); peek(3'd0, d);
            chk("cap_lat2", 16'(d[10]), 16'h0000);
            @(negedge clk); peek(3'd0, d);
            chk("cap_lat3", 16'(d[10]), 16'h0001);
            peek(3'd4, d);
            chk("cap_value", d, tgt);
        end

        // Channel 1 match: flag appears on the tick where T0 becomes 0x0010
        wr(3'd0, 16'h000E, 1'b0, 1'b1);
        wr(3'd3, 16'h0010, 1'b1, 1'b1);
        wr(3'd2, 16'h0000, 1'b1, 1'b1);
        wr(3'd0, 16'h4000, 1'b1, 1'b0);
        wr(3'd0, 16'h001E, 1'b0, 1'b1);
        found = 1'b0;
        d2 = 16'h0000;
        for (int i = 0; i < 120 && !found; i++) begin
            @(negedge clk);
            peek(3'd0, d);
            peek(3'd2, d2);
            found = d[14];
        end
        chk("match_seen", 16'(found), 16'h0001);
        chk("match_t0", d2, 16'h0010);
        bus_if.addr = 3'd2;
        bus_if.cs   = 1'b0;
        #1;
        chk("rdata_idle", bus_if.rdata, 16'h0000);

        // Same-cycle W1C and overflow, then lower-lane-only write to T0
        wr(3'd1, 16'h0000, 1'b1, 1'b1);
        wr(3'd0, 16'hFE0E, 1'b1, 1'b1);
        wr(3'd2, 16'hFFFE, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            peek(3'd2, d);
            found = (d == 16'hFFFF);
        end
        chk("ov_align", 16'(found), 16'h0001);
        step(2);
        wr(3'd0, 16'h8000, 1'b1, 1'b0);
        peek(3'd0, d);
        chk("ov_set_wins", 16'(d[15]), 16'h0001);
        chk("cr_untouched", {8'h00, d[7:0]}, 16'h000E);
        peek(3'd2, d);
        chk("t0_reload0", d, 16'h0000);
        wr(3'd2, 16'hABCD, 1'b0, 1'b1);
        peek(3'd2, d);
        chk("t0_lds_only", d, 16'h00CD);

        // Reset mid-operation with flags set
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            peek(3'(a), d);
            chk($sformatf("midreset_word%0d", a), d, 16'h0000);
        end
        chk("midreset_irq", 16'(irq), 16'h0000);
        reset = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
